// File: rtl/gps_pkg.sv
// Shared types, widths, PRN tap table and small helpers for the GPS L1 C/A front-end.
package gps_pkg;

  localparam int ACC_W = 32;

  // 3-bit sign-magnitude ADC sample: value = +/-(2*mag+1)
  typedef struct packed {
    logic       neg;
    logic [1:0] mag;
  } sample_t;

  // Signed 2-bit mixed output, only -1/0/+1 are ever produced
  typedef logic signed [1:0] out_t;

  // First pipeline stage: sample plus the carrier/code signs seen with it
  typedef struct packed {
    logic    valid;
    sample_t smp;
    logic    carr_neg;
    logic    chip;
  } stage1_t;

  // G2 phase-select tap pairs for PRN 1..32, {tapA, tapB} as nibbles (10 = 'hA)
  localparam logic [7:0] PRN_TAPS [32] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2A, 8'h18, 8'h29,
    8'h3A, 8'h23, 8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9A,
    8'h14, 8'h25, 8'h36, 8'h47, 8'h58, 8'h69, 8'h13, 8'h46,
    8'h57, 8'h68, 8'h79, 8'h8A, 8'h16, 8'h27, 8'h38, 8'h49
  };

  // Map a sign bit (1 = negative) to a signed +/-1
  function automatic out_t sign_to_pm1(input logic neg);
    return neg ? 2'sb11 : 2'sb01;
  endfunction

endpackage

// File: rtl/gps_frontend_top_ca_code_gen.sv
// C/A Gold code generator: G1/G2 LFSRs with PRN-selected G2 phase taps.
module ca_code_gen
  import gps_pkg::*;
#(
  parameter int PRN = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic adv,
  output logic chip
);

  localparam logic [7:0] TAPS  = PRN_TAPS[PRN-1];
  localparam int         TAP_A = int'(TAPS[7:4]);
  localparam int         TAP_B = int'(TAPS[3:0]);

  // Registers numbered 1..10 so indices match the usual LFSR stage names
  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;

  // Shift both LFSRs one chip when advanced; output follows current state
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (adv) begin
      g1_d = {g1_q[9:1], g1_q[3] ^ g1_q[10]};
      g2_d = {g2_q[9:1], g2_q[2] ^ g2_q[3] ^ g2_q[6] ^ g2_q[8] ^ g2_q[9] ^ g2_q[10]};
    end
    chip = g1_q[10] ^ g2_q[TAP_A] ^ g2_q[TAP_B];
  end

  // LFSR state, seeded to all ones so every reset restarts at chip 0
  always_ff @(posedge CLK) begin
    if (RST) begin
      g1_q <= 10'h3FF;
      g2_q <= 10'h3FF;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

endmodule

// File: rtl/gps_frontend_top.sv
// GPS L1 C/A front-end: requantize, carrier wipe-off and code wipe-off, 2-clock latency.
module gps_frontend_top
  import gps_pkg::*;
#(
  parameter logic [ACC_W-1:0] CARRIER_FCW = 32'd1073741824,
  parameter logic [ACC_W-1:0] CODE_FCW    = 32'd439375154,
  parameter int               PRN         = 1,
  parameter int               MAG_THRESH  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] data_in,
  output logic [1:0] data_out
);

  localparam logic [1:0] THR = 2'(MAG_THRESH);

  logic [ACC_W-1:0] carr_acc_q, carr_acc_d;
  logic [ACC_W-1:0] code_acc_q, code_acc_d;
  logic             code_carry;
  logic             chip;
  stage1_t          stage1_q, stage1_d;
  out_t             out_q, out_d;

  ca_code_gen #(.PRN(PRN)) u_ca (
    .CLK  (CLK),
    .RST  (RST),
    .adv  (code_carry),
    .chip (chip)
  );

  // NCO updates, stage-1 capture and mixer product from stage 1
  always_comb begin
    carr_acc_d = carr_acc_q + CARRIER_FCW;
    {code_carry, code_acc_d} = {1'b0, code_acc_q} + {1'b0, CODE_FCW};

    stage1_d.valid    = 1'b1;
    stage1_d.smp      = sample_t'(data_in);
    stage1_d.carr_neg = carr_acc_q[ACC_W-1];
    stage1_d.chip     = chip;

    // valid keeps the flushed stage from producing a nonzero output at any threshold
    out_d = '0;
    if (stage1_q.valid && (stage1_q.smp.mag >= THR)) begin
      out_d = sign_to_pm1(stage1_q.smp.neg ^ stage1_q.carr_neg ^ stage1_q.chip);
    end
  end

  // Accumulators and pipeline registers, all cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      carr_acc_q <= '0;
      code_acc_q <= '0;
      stage1_q   <= '0;
      out_q      <= '0;
    end else begin
      carr_acc_q <= carr_acc_d;
      code_acc_q <= code_acc_d;
      stage1_q   <= stage1_d;
      out_q      <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_gps_frontend_top.sv
// Directed bench for gps_frontend_top: three instances with different NCO settings.
module tb_gps_frontend_top;

  localparam logic [1:0] P = 2'b01;
  localparam logic [1:0] N = 2'b11;
  localparam logic [1:0] Z = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] a_in, b_in, c_in;
  logic [1:0] a_out, b_out, c_out;

  // Bench-only sample source: 3-bit RAM read at an incrementing address
  logic [2:0] ram_mem [8];
  logic [2:0] ram_addr;
  assign c_in = ram_mem[ram_addr];

  int n_pass  = 0;
  int n_total = 0;

  // Expected patterns, hand-derived
  logic [1:0] a_pos [4] = '{N, N, P, P};
  logic [1:0] a_neg [4] = '{P, P, N, N};
  logic [1:0] c_pat [8] = '{Z, Z, N, N, Z, Z, P, P};
  logic       b_chip [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  // Carrier 2.5 MHz, code frozen
  gps_frontend_top #(.CARRIER_FCW(32'd1073741824), .CODE_FCW(32'd0), .PRN(1), .MAG_THRESH(2)) dut_a (
    .CLK(clk), .RST(rst), .data_in(a_in), .data_out(a_out));

  // Carrier frozen, one chip every two clocks
  gps_frontend_top #(.CARRIER_FCW(32'd0), .CODE_FCW(32'h8000_0000), .PRN(1), .MAG_THRESH(2)) dut_b (
    .CLK(clk), .RST(rst), .data_in(b_in), .data_out(b_out));

  // Both frozen, fed by the RAM ramp
  gps_frontend_top #(.CARRIER_FCW(32'd0), .CODE_FCW(32'd0), .PRN(1), .MAG_THRESH(2)) dut_c (
    .CLK(clk), .RST(rst), .data_in(c_in), .data_out(c_out));

  task automatic tick();
    @(posedge clk);
    #1;
    if (!rst) ram_addr = ram_addr + 3'd1;
  endtask

  task automatic chk(input string tag, input int idx, input logic [1:0] obs, input logic [1:0] exp);
    n_total++;
    $display("check %s[%0d] obs=%0d exp=%0d", tag, idx, $signed(obs), $signed(exp));
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
  endtask

  function automatic logic [1:0] chip_val(input logic c);
    return c ? N : P;
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) ram_mem[i] = 3'(i);
    ram_addr = 3'd0;
    rst  = 1'b1;
    a_in = 3'b011;
    b_in = 3'b011;

    // Reset held two edges, then first edge after release still zero
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_a", i, a_out, Z);
      chk("rst_b", i, b_out, Z);
      chk("rst_c", i, c_out, Z);
    end
    rst = 1'b0;
    tick();
    chk("lat_a", 0, a_out, Z);
    chk("lat_b", 0, b_out, Z);
    chk("lat_c", 0, c_out, Z);

    // Main run: carrier pattern, held chips, ramp; then code period check
    for (int j = 1; j <= 2066; j++) begin
      tick();
      if (j <= 20) begin
        chk("carr_p7", j, a_out, a_pos[(j-1)%4]);
        chk("chip", j, b_out, chip_val(b_chip[(j-1)/2]));
        chk("ramp", j, c_out, c_pat[(j-1)%8]);
      end else if (j >= 2047) begin
        chk("chip_wrap", j, b_out, chip_val(b_chip[(j-2047)/2]));
      end
    end

    // Mid-stream reset pulse: flush then bit-identical restart
    rst = 1'b1;
    ram_addr = 3'd0;
    tick();
    chk("mid_rst_a", 0, a_out, Z);
    chk("mid_rst_b", 0, b_out, Z);
    rst = 1'b0;
    tick();
    chk("mid_lat_a", 0, a_out, Z);
    chk("mid_lat_c", 0, c_out, Z);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("restart_a", j, a_out, a_pos[(j-1)%4]);
      chk("restart_b", j, b_out, chip_val(b_chip[(j-1)/2]));
      chk("restart_c", j, c_out, c_pat[(j-1)%8]);
    end

    // Negative full-scale input inverts the carrier pattern
    rst = 1'b1;
    a_in = 3'b111;
    tick();
    chk("neg_rst", 0, a_out, Z);
    rst = 1'b0;
    tick();
    chk("neg_lat", 0, a_out, Z);
    for (int j = 1; j <= 8; j++) begin
      tick();
      chk("carr_m7", j, a_out, a_neg[(j-1)%4]);
    end

    // Small magnitudes requantize to zero; old sample still drains for one edge
    a_in = 3'b000;
    tick();
    chk("drain", 9, a_out, a_neg[0]);
    for (int j = 10; j <= 13; j++) begin
      tick();
      chk("small_000", j, a_out, Z);
    end
    a_in = 3'b001;
    for (int j = 14; j <= 17; j++) begin
      tick();
      chk("small_001", j, a_out, Z);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
